// File: rtl/control_unit_mc.sv
// Multicycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, stalls on mem_ready,
// traps illegal opcodes and memory timeouts, and counts retired instructions.
module control_unit_mc #(
    parameter int CNT_W       = 32,
    parameter int TO_W        = 5,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCen,
    output logic [1:0]       PCSrc,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemToReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count,
    output logic             fault,
    output logic [1:0]       fault_code
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    function automatic logic is_legal(input logic [5:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_J, OP_BEQ, OP_BNE: ok = 1'b1;
            default:                                              ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t           state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [TO_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;
    logic [1:0]       code_q, code_d;
    logic             retire_s;
    logic             limit_s;

    // Last permitted not-ready cycle of the current memory access.
    assign limit_s = (MEM_TIMEOUT != 0) && (wait_cnt_q == TO_W'(MEM_TIMEOUT - 1));

    // State and bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= 6'b000000;
            wait_cnt_q <= '0;
            cnt_q      <= '0;
            fault_q    <= 1'b0;
            code_q     <= 2'b00;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wait_cnt_q <= wait_cnt_d;
            cnt_q      <= cnt_d;
            fault_q    <= fault_d;
            code_q     <= code_d;
        end
    end

    // Next-state, retire and timeout logic; wait_cnt falls back to zero whenever not stalling.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        wait_cnt_d = '0;
        fault_d    = fault_q;
        code_d     = code_q;
        retire_s   = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH, S_MEM: begin
                if (mem_ready) begin
                    if (state_q == S_FETCH) begin
                        state_d = S_DECODE;
                    end else if (op_q == OP_LW) begin
                        state_d = S_WB;
                    end else begin
                        state_d  = S_FETCH;
                        retire_s = 1'b1;
                    end
                end else if (limit_s) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                    code_d  = FC_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + TO_W'(1);
                end
            end
            S_DECODE: begin
                op_d = opcode;
                if (is_legal(opcode)) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                    code_d  = FC_ILLEGAL;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_RTYPE, OP_ADDI: state_d = S_WB;
                    OP_LW, OP_SW:      state_d = S_MEM;
                    OP_BEQ, OP_BNE, OP_J: begin
                        state_d  = S_FETCH;
                        retire_s = 1'b1;
                    end
                    default: begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                        code_d  = FC_ILLEGAL;
                    end
                endcase
            end
            S_WB: begin
                state_d  = S_FETCH;
                retire_s = 1'b1;
            end
            S_FAULT: state_d = S_FAULT;
            default: begin
                state_d = S_FAULT;
                fault_d = 1'b1;
            end
        endcase
        cnt_d = retire_s ? (cnt_q + CNT_W'(1)) : cnt_q;
    end

    // Datapath controls as Moore functions of state/op_q, plus the handshake and zero terms.
    always_comb begin
        PCen     = 1'b0;
        PCSrc    = 2'b00;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        MemToReg = 1'b0;
        RegDst   = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = 2'b00;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCen    = mem_ready;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_EXEC: begin
                case (op_q)
                    OP_RTYPE: begin
                        ALUSrcA = 1'b1;
                        ALUOp   = 2'b10;
                    end
                    OP_ADDI, OP_LW, OP_SW: begin
                        ALUSrcA = 1'b1;
                        ALUSrcB = 2'b10;
                    end
                    OP_BEQ, OP_BNE: begin
                        ALUSrcA = 1'b1;
                        ALUOp   = 2'b01;
                        PCSrc   = 2'b01;
                        PCen    = (op_q == OP_BEQ) ? zero : ~zero;
                    end
                    OP_J: begin
                        PCSrc = 2'b10;
                        PCen  = 1'b1;
                    end
                    default: PCen = 1'b0;
                endcase
            end
            S_MEM: begin
                IorD     = 1'b1;
                MemRead  = (op_q == OP_LW);
                MemWrite = (op_q == OP_SW);
            end
            S_WB: begin
                RegWrite = 1'b1;
                RegDst   = (op_q == OP_RTYPE);
                MemToReg = (op_q == OP_LW);
            end
            default: RegWrite = 1'b0;
        endcase
    end

    assign state       = state_q;
    assign instr_count = cnt_q;
    assign fault       = fault_q;
    assign fault_code  = code_q;

endmodule

// File: tb/tb_control_unit_mc.sv
// Directed scoreboard bench for control_unit_mc: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_control_unit_mc;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_I   = 6'b001000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_BAD = 6'b111111;

    // ctl = {PCen,PCSrc,IorD,MemRead,MemWrite,IRWrite,MemToReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp}
    localparam logic [14:0] C_ZERO  = 15'b0_00_0_0_0_0_0_0_0_0_00_00;
    localparam logic [14:0] C_FW    = 15'b0_00_0_1_0_0_0_0_0_0_01_00;
    localparam logic [14:0] C_FR    = 15'b1_00_0_1_0_1_0_0_0_0_01_00;
    localparam logic [14:0] C_DEC   = 15'b0_00_0_0_0_0_0_0_0_0_11_00;
    localparam logic [14:0] C_EX_R  = 15'b0_00_0_0_0_0_0_0_0_1_00_10;
    localparam logic [14:0] C_EX_IM = 15'b0_00_0_0_0_0_0_0_0_1_10_00;
    localparam logic [14:0] C_BR_T  = 15'b1_01_0_0_0_0_0_0_0_1_00_01;
    localparam logic [14:0] C_BR_NT = 15'b0_01_0_0_0_0_0_0_0_1_00_01;
    localparam logic [14:0] C_EX_J  = 15'b1_10_0_0_0_0_0_0_0_0_00_00;
    localparam logic [14:0] C_M_LW  = 15'b0_00_1_1_0_0_0_0_0_0_00_00;
    localparam logic [14:0] C_M_SW  = 15'b0_00_1_0_1_0_0_0_0_0_00_00;
    localparam logic [14:0] C_WB_R  = 15'b0_00_0_0_0_0_0_1_1_0_00_00;
    localparam logic [14:0] C_WB_I  = 15'b0_00_0_0_0_0_0_0_1_0_00_00;
    localparam logic [14:0] C_WB_LW = 15'b0_00_0_0_0_0_1_0_1_0_00_00;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       PCen, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] PCSrc, ALUSrcB, ALUOp;
    logic [2:0] state;
    logic [3:0] instr_count;
    logic       fault;
    logic [1:0] fault_code;

    typedef struct {
        logic [2:0]  st;
        logic [14:0] ctl;
        logic [3:0]  cnt;
        logic        f;
        logic [1:0]  code;
        string       nm;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] exp_cnt;
    logic       exp_fault;
    logic [1:0] exp_code;
    int         checks = 0;
    int         errors = 0;

    control_unit_mc #(.CNT_W(4), .TO_W(5), .MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCen(PCen), .PCSrc(PCSrc), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .state(state),
        .instr_count(instr_count), .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t       e;
        logic [14:0] ctl;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            ctl = {PCen, PCSrc, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst,
                   RegWrite, ALUSrcA, ALUSrcB, ALUOp};
            checks++;
            if (state !== e.st || ctl !== e.ctl || instr_count !== e.cnt ||
                fault !== e.f || fault_code !== e.code) begin
                errors++;
                $display("FAIL %s: got st=%0d ctl=%b cnt=%0d fault=%b code=%b, expected st=%0d ctl=%b cnt=%0d fault=%b code=%b",
                         e.nm, state, ctl, instr_count, fault, fault_code,
                         e.st, e.ctl, e.cnt, e.f, e.code);
            end
        end
    end

    task automatic cyc(input logic [5:0] op, input logic z, input logic mr,
                       input logic [2:0] st, input logic [14:0] ctl, input string nm);
        exp_t e;
        opcode    = op;
        zero      = z;
        mem_ready = mr;
        e.st = st; e.ctl = ctl; e.cnt = exp_cnt; e.f = exp_fault; e.code = exp_code; e.nm = nm;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        exp_cnt = 4'd0; exp_fault = 1'b0; exp_code = 2'b00;
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc(OP_R, 1'b0, 1'b1, 3'd0, C_ZERO, "reset_held");
        rst = 1'b0;
        cyc(OP_R, 1'b0, 1'b1, 3'd0, C_ZERO, "reset_idle");
    endtask

    task automatic fetch_decode(input logic [5:0] op);
        cyc(op, 1'b0, 1'b1, 3'd1, C_FR, "fetch");
        cyc(op, 1'b0, 1'b0, 3'd2, C_DEC, "decode");
    endtask

    initial begin
        rst = 1'b1; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b0;
        exp_cnt = 4'd0; exp_fault = 1'b0; exp_code = 2'b00;

        // addi: 0,1,2,3,5,1
        do_reset();
        fetch_decode(OP_I);
        cyc(OP_I, 1'b0, 1'b0, 3'd3, C_EX_IM, "addi_exec");
        cyc(OP_I, 1'b0, 1'b0, 3'd5, C_WB_I, "addi_wb");
        exp_cnt++;
        // lw with three MEM stalls
        fetch_decode(OP_LW);
        cyc(OP_LW, 1'b0, 1'b0, 3'd3, C_EX_IM, "lw_exec");
        for (int i = 0; i < 3; i++) cyc(OP_LW, 1'b0, 1'b0, 3'd4, C_M_LW, "lw_mem_wait");
        cyc(OP_LW, 1'b0, 1'b1, 3'd4, C_M_LW, "lw_mem_ready");
        cyc(OP_LW, 1'b0, 1'b0, 3'd5, C_WB_LW, "lw_wb");
        exp_cnt++;
        // sw, R-type
        fetch_decode(OP_SW);
        cyc(OP_SW, 1'b0, 1'b0, 3'd3, C_EX_IM, "sw_exec");
        cyc(OP_SW, 1'b0, 1'b1, 3'd4, C_M_SW, "sw_mem");
        exp_cnt++;
        fetch_decode(OP_R);
        cyc(OP_R, 1'b0, 1'b0, 3'd3, C_EX_R, "r_exec");
        cyc(OP_R, 1'b0, 1'b0, 3'd5, C_WB_R, "r_wb");
        exp_cnt++;
        // branches taken / not taken
        fetch_decode(OP_BEQ);
        cyc(OP_BEQ, 1'b1, 1'b0, 3'd3, C_BR_T, "beq_taken");
        exp_cnt++;
        fetch_decode(OP_BEQ);
        cyc(OP_BEQ, 1'b0, 1'b0, 3'd3, C_BR_NT, "beq_not_taken");
        exp_cnt++;
        fetch_decode(OP_BNE);
        cyc(OP_BNE, 1'b0, 1'b0, 3'd3, C_BR_T, "bne_taken");
        exp_cnt++;
        fetch_decode(OP_BNE);
        cyc(OP_BNE, 1'b1, 1'b0, 3'd3, C_BR_NT, "bne_not_taken");
        exp_cnt++;
        // illegal opcode: sticky FAULT, then asynchronous reset
        fetch_decode(OP_BAD);
        exp_fault = 1'b1; exp_code = 2'b01;
        for (int i = 0; i < 100; i++) cyc(OP_BAD, 1'b0, i[0], 3'd6, C_ZERO, "illegal_hold");
        rst = 1'b1;
        exp_cnt = 4'd0; exp_fault = 1'b0; exp_code = 2'b00;
        cyc(OP_R, 1'b0, 1'b0, 3'd0, C_ZERO, "async_reset");
        rst = 1'b0;
        cyc(OP_R, 1'b0, 1'b0, 3'd0, C_ZERO, "post_async_idle");

        // fetch timeout: 16 not-ready cycles, then FAULT
        for (int i = 0; i < 16; i++) cyc(OP_J, 1'b0, 1'b0, 3'd1, C_FW, "to_wait");
        exp_fault = 1'b1; exp_code = 2'b10;
        for (int i = 0; i < 3; i++) cyc(OP_J, 1'b0, 1'b0, 3'd6, C_ZERO, "to_fault");
        // ready on the 16th cycle wins
        do_reset();
        for (int i = 0; i < 15; i++) cyc(OP_J, 1'b0, 1'b0, 3'd1, C_FW, "to_wait2");
        cyc(OP_J, 1'b0, 1'b1, 3'd1, C_FR, "to_ready_last");
        cyc(OP_J, 1'b0, 1'b0, 3'd2, C_DEC, "to_decode");

        // 17 jumps wrap the 4-bit counter to 1
        do_reset();
        for (int k = 0; k < 17; k++) begin
            fetch_decode(OP_J);
            cyc(OP_J, 1'b0, 1'b0, 3'd3, C_EX_J, "j_exec");
            exp_cnt++;
        end
        cyc(OP_J, 1'b0, 1'b0, 3'd1, C_FW, "wrap_fetch");

        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit_mc.md
# control_unit_mc

Multicycle control FSM for the MIPS CPU. It replaces the single-cycle opcode decoder with a parametrised state machine that sequences FETCH/DECODE/EXEC/MEM/WB, stalls on a memory-ready handshake, and traps illegal opcodes and memory timeouts. It also counts retired instructions. It sits between the instruction register opcode field, the ALU zero flag, and the datapath muxes/enables of the 32/64-bit datapath.

## Interface
- CNT_W, 32, width of the retired-instruction counter
- TO_W, 5, width of the memory wait counter
- MEM_TIMEOUT, 16, not-ready cycles tolerated per memory access; 0 disables the timeout; must be < 2^TO_W

- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- opcode  in  6  IR[31:26], valid from DECODE onward
- zero  in  1  ALU zero flag, combinational, sampled in EXEC
- mem_ready  in  1  memory completes the current access this cycle
- PCen  out  1  PC write enable
- PCSrc  out  2  PC source: 00 ALU result, 01 ALUOut (branch target), 10 jump target
- IorD  out  1  memory address: 0 PC, 1 ALUOut
- MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA  out  1 each  datapath controls
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- ALUOp  out  2  00 add, 01 sub, 10 decode funct
- state  out  3  current state, for debug
- instr_count  out  CNT_W  retired instructions
- fault  out  1  sticky fault flag
- fault_code  out  2  00 none, 01 illegal opcode, 10 memory timeout

## Operation
- Supported opcodes: R-type 000000, addi 001000, lw 100011, sw 101011, j 000010, beq 000100, bne 000101. All others are illegal.
- The state encoding is fixed: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=6.
- Outputs are Moore functions of the state and op_q. op_q is the opcode latched at the end of DECODE. Any output not listed for a state is 0.
- **IDLE**: all outputs are 0. Go to FETCH next cycle.
- **FETCH**:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite and PCen equal mem_ready.
  - If mem_ready, go to DECODE; otherwise stay.
- **DECODE**:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - Latch op_q.
  - Illegal opcode: go to FAULT with fault_code=01. Otherwise go to EXEC.
- **EXEC** (driven by op_q):
  - R-type: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to WB.
  - addi: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to WB.
  - lw/sw: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEM.
  - beq: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, PCen=zero. Go to FETCH.
  - bne: same as beq but PCen=!zero.
  - j: PCSrc=10, PCen=1. Go to FETCH.
- **MEM**:
  - IorD=1. lw drives MemRead=1; sw drives MemWrite=1.
  - While mem_ready=0, stay.
  - When mem_ready=1: lw goes to WB, sw goes to FETCH.
- **WB**: RegWrite=1. RegDst=1 only for R-type. MemToReg=1 only for lw. Go to FETCH.
- **FAULT**: all datapath outputs 0, fault=1, fault_code holds its value. Only reset exits.
- **Retire**: instr_count increments by 1 on every transition into FETCH from EXEC, MEM or WB. It wraps modulo 2^CNT_W.
- **Timeout**:
  - wait_cnt clears on every entry into FETCH or MEM.
  - Each FETCH/MEM cycle with mem_ready=0: if MEM_TIMEOUT≠0 and wait_cnt==MEM_TIMEOUT-1, go to FAULT with fault_code=10; otherwise wait_cnt increments.
  - If mem_ready=1 in the same cycle the limit would be reached, ready wins and there is no fault.

## Timing
- **Reset**: while rst=1 and on the first edge after release, state=IDLE. op_q=0, wait_cnt=0, instr_count=0, fault=0, fault_code=00; every output is 0.
- **Reset mid-operation**: asynchronous. Outputs go to reset values without waiting for a clock edge. In-flight accesses are abandoned.
- **Cycles per instruction with zero-wait memory**: R-type, addi and sw take 4; lw takes 5; beq, bne and j take 3. Each FETCH/MEM stall cycle adds 1.
- **First fetch**: MemRead=1 in the second cycle after rst deasserts (IDLE occupies one cycle).
- **zero**: must be valid combinationally in the EXEC cycle. The PC update takes effect at the EXEC→FETCH edge.
- **Timeout**: with MEM_TIMEOUT=N, the (N+1)-th consecutive not-ready cycle is FAULT.

## Test plan
- **Reset, then addi, zero-wait memory**: state sequence 0,1,2,3,5,1. RegWrite=1 only in WB with RegDst=0. instr_count=1.
- **lw with mem_ready low 3 cycles in MEM, zero-wait fetch**: MEM lasts 4 cycles. WB follows with MemToReg=1. 8 cycles from FETCH to the next FETCH. No fault.
- **beq with zero=1 then beq with zero=0**: PCen=1, PCSrc=01 in the first EXEC; PCen=0 in the second. Each instruction takes 3 cycles. instr_count increments by 2.
- **Opcode 111111**: FAULT after DECODE, fault=1, fault_code=01. State stays 6 for 100 cycles. Async rst returns everything to 0 immediately.
- **MEM_TIMEOUT=16, mem_ready held 0 in FETCH**: FAULT with fault_code=10 on the 17th cycle. Repeat with mem_ready=1 on the 16th cycle: no fault, goes to DECODE.
- **CNT_W=4, 17 j instructions**: instr_count wraps to 1.
